// File: rtl/sprite_pkg.sv
// sprite_pkg: shared geometry constants, request record and range check for the sprite ROM path.
package sprite_pkg;

  // Sprite sheet geometry: 16 headings of 75x75 px laid out as an 8x2 sheet.
  localparam int unsigned SPRITE_W  = 75;
  localparam int unsigned SHEET_W   = 600;
  localparam int unsigned NUM_DIRS  = 16;
  localparam int unsigned ROM_DEPTH = 90000;
  localparam int unsigned ROM_AW    = 17;

  // Request field widths.
  localparam int unsigned DEG_W   = 9;
  localparam int unsigned COORD_W = 7;

  // Largest legal heading and local coordinate.
  localparam logic [DEG_W-1:0]   DEG_MAX   = 9'd359;
  localparam logic [COORD_W-1:0] COORD_MAX = 7'd74;

  // Pixel defaults (RGB444, black is the transparent key).
  localparam int unsigned    DEF_DATA_W      = 12;
  localparam logic [11:0]    DEF_TRANSPARENT = 12'h000;

  typedef struct packed {
    logic [DEG_W-1:0]   degree;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_req_t;

  // True when the request addresses a real pixel inside the sheet.
  function automatic logic req_in_range(input sprite_req_t r);
    return (r.degree <= DEG_MAX) && (r.x <= COORD_MAX) && (r.y <= COORD_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; returns one-hot grant and the
// pointer value that follows the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     next_ptr
);

  // Walk the requesters in circular order from ptr and take the first active one.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = IdW'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: shares the rotated-sprite ROM between NUM_REQ pixel requesters.
// One round-robin grant per cycle feeds the registered address-calc inputs, the ROM read is
// issued the next cycle and the pixel returns ROM_LATENCY+2 cycles after the accept.
// Optional build macro SPRITE_ARB_STATS_EN adds per-requester grant and stall counters.
module sprite_fetch_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned        NUM_REQ     = 2,
  parameter int unsigned        ROM_LATENCY = 1,
  parameter int unsigned        DATA_W      = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  TRANSPARENT = DATA_W'(DEF_TRANSPARENT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DEG_W-1:0]   req_degree,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [DEG_W-1:0]           calc_degree,
  output logic [COORD_W-1:0]         calc_x,
  output logic [COORD_W-1:0]         calc_y,
  input  logic [ROM_AW-1:0]          calc_addr,
  output logic                       rom_en_o,
  output logic [ROM_AW-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      stat_grants,
  output logic [NUM_REQ*16-1:0]      stat_stalls
`endif
);

  localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TagDepth = ROM_LATENCY + 1;

  // One entry per read in flight; the last stage lines up with valid ROM data.
  typedef struct packed {
    logic           vld;
    logic [IdW-1:0] id;
    logic           oor;
  } tag_t;

  logic [IdW-1:0]     ptr_q;
  logic [IdW-1:0]     arb_next_ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic               accept;
  logic [IdW-1:0]     acc_id;
  sprite_req_t        acc_req;
  logic               acc_oor;
  tag_t               tag_q [TagDepth];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .next_ptr (arb_next_ptr)
  );

  // Grants are suppressed while reset is held so nothing is accepted into a clearing pipe.
  assign req_ready = rst ? '0 : arb_grant;
  assign accept    = |req_ready;

  // Select the winning requester's id and fields.
  always_comb begin
    acc_id  = '0;
    acc_req = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        acc_id         = IdW'(i);
        acc_req.degree = req_degree[i*DEG_W +: DEG_W];
        acc_req.x      = req_x[i*COORD_W +: COORD_W];
        acc_req.y      = req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  assign acc_oor = !req_in_range(acc_req);

  // The calc result is passed through untouched; the bus idles at zero between reads.
  assign rom_addr_o = rom_en_o ? calc_addr : '0;

  // Round-robin pointer; frame_start wins over the advance from a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (frame_start) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= arb_next_ptr;
    end
  end

  // Address-calc operand registers and ROM read enable for the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      calc_degree <= '0;
      calc_x      <= '0;
      calc_y      <= '0;
      rom_en_o    <= 1'b0;
    end else begin
      if (accept) begin
        calc_degree <= acc_req.degree;
        calc_x      <= acc_req.x;
        calc_y      <= acc_req.y;
      end
      rom_en_o <= accept && !acc_oor;
    end
  end

  // Tag shift register tracking owner and range status alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < TagDepth; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: accept, id: acc_id, oor: acc_oor};
      for (int unsigned s = 1; s < TagDepth; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Registered response: route the pixel to its owner, substituting the transparent key.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_valid[i] <= tag_q[TagDepth-1].vld && (tag_q[TagDepth-1].id == IdW'(i));
      end
      if (tag_q[TagDepth-1].vld) begin
        rsp_data <= tag_q[TagDepth-1].oor ? TRANSPARENT : rom_data_i;
      end
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  // Saturating per-requester accept and stall counters, cleared every frame.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (stat_grants[i*16 +: 16] != 16'hFFFF)) begin
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
        end
        if (req_valid[i] && !req_ready[i] && (stat_stalls[i*16 +: 16] != 16'hFFFF)) begin
          stat_stalls[i*16 +: 16] <= stat_stalls[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb_sprite_fetch_arbiter: directed and randomized checks of sprite_fetch_arbiter against a
// cycle-scheduled reference model, with a behavioural address calc and ROM.
// Define SPRITE_ARB_STATS_EN to also exercise the statistics ports.
module tb_sprite_fetch_arbiter;

  localparam int NR = 2;
  localparam int L  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*9-1:0]  req_degree;
  logic [NR*7-1:0]  req_x;
  logic [NR*7-1:0]  req_y;
  logic [NR-1:0]    rsp_valid;
  logic [11:0]      rsp_data;
  logic [8:0]       calc_degree;
  logic [6:0]       calc_x;
  logic [6:0]       calc_y;
  logic [16:0]      calc_addr;
  logic             rom_en_o;
  logic [16:0]      rom_addr_o;
  logic [11:0]      rom_data_i;
`ifdef SPRITE_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [NR*16-1:0] stat_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;

  sprite_fetch_arbiter #(
    .NUM_REQ     (NR),
    .ROM_LATENCY (L),
    .DATA_W      (12),
    .TRANSPARENT (12'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_degree  (req_degree),
    .req_x       (req_x),
    .req_y       (req_y),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .calc_degree (calc_degree),
    .calc_x      (calc_x),
    .calc_y      (calc_y),
    .calc_addr   (calc_addr),
    .rom_en_o    (rom_en_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Sheet address: heading bucket picks a 75x75 cell in the 8x2 grid.
  function automatic logic [16:0] addr_of(input int d, input int x, input int y);
    int dir;
    int row;
    int col;
    dir = d * 16 / 360;
    row = dir / 8;
    col = dir % 8;
    return 17'((row * 75 + y) * 600 + col * 75 + x);
  endfunction

  function automatic logic [11:0] rom_word(input logic [16:0] a);
    return a[11:0] ^ 12'hA5C ^ {7'd0, a[16:12]};
  endfunction

  assign calc_addr = addr_of(int'(calc_degree), int'(calc_x), int'(calc_y));

  // ROM with L-cycle latency; unread cycles return a poison value.
  logic [11:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en_o ? rom_word(rom_addr_o) : 12'hBAD;
    for (int s = 1; s < L; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_data_i = rom_pipe[L-1];

  // ---------------- reference model ----------------
  int          mptr = 0;
  int          cyc  = 0;
  logic [NR-1:0] exp_ready;
  logic        slot_rsp [8];
  int          slot_id  [8];
  logic [11:0] slot_dat [8];
  logic        slot_en  [8];
  logic [16:0] slot_adr [8];
  logic [NR-1:0] exp_rsp_valid;
  logic [11:0] exp_rsp_data;
  logic        exp_en;
  logic [16:0] exp_addr;
  logic [8:0]  exp_cd;
  logic [6:0]  exp_cx;
  logic [6:0]  exp_cy;

  // Winner = first valid requester at or after the pointer, circularly.
  always_comb begin
    exp_ready = '0;
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin
        if (exp_ready == '0 && req_valid[(mptr + k) % NR]) exp_ready[(mptr + k) % NR] = 1'b1;
      end
    end
  end

  // Expected outputs for the cycle following each edge, scheduled by absolute cycle number.
  always @(posedge clk) begin
    int n;
    int w;
    int d;
    int x;
    int y;
    logic oor;
    n = cyc + 1;
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        slot_rsp[s] = 1'b0;
        slot_en[s]  = 1'b0;
      end
      mptr = 0;
      exp_rsp_valid = '0;
      exp_rsp_data  = '0;
      exp_en = 1'b0;
      exp_addr = '0;
      exp_cd = '0;
      exp_cx = '0;
      exp_cy = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NR; k++) if (exp_ready[k]) w = k;
      if (w >= 0) begin
        d = int'(req_degree[w*9 +: 9]);
        x = int'(req_x[w*7 +: 7]);
        y = int'(req_y[w*7 +: 7]);
        oor = (d > 359) || (x > 74) || (y > 74);
        exp_cd = 9'(d);
        exp_cx = 7'(x);
        exp_cy = 7'(y);
        slot_en[n % 8]  = !oor;
        slot_adr[n % 8] = addr_of(d, x, y);
        slot_rsp[(n + L + 1) % 8] = 1'b1;
        slot_id[(n + L + 1) % 8]  = w;
        slot_dat[(n + L + 1) % 8] = oor ? 12'h000 : rom_word(addr_of(d, x, y));
        mptr = frame_start ? 0 : (w + 1) % NR;
      end else if (frame_start) begin
        mptr = 0;
      end
      exp_en   = slot_en[n % 8];
      exp_addr = slot_adr[n % 8];
      slot_en[n % 8] = 1'b0;
      exp_rsp_valid = '0;
      if (slot_rsp[n % 8]) begin
        exp_rsp_valid[slot_id[n % 8]] = 1'b1;
        exp_rsp_data = slot_dat[n % 8];
      end
      slot_rsp[n % 8] = 1'b0;
    end
    cyc = n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input int d, input int x, input int y);
    req_degree[i*9 +: 9] = 9'(d);
    req_x[i*7 +: 7]      = 7'(x);
    req_y[i*7 +: 7]      = 7'(y);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    req_valid = '1;
    req_degree = '0;
    req_x = '0;
    req_y = '0;
    set_req(0, 10, 5, 5);
    set_req(1, 20, 6, 6);
    tick();
    tick();
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    n_vec++; if (rsp_data !== 12'h000) begin n_err++; $display("FAIL reset_rsp_data got %h want 000", rsp_data); end
    n_vec++; if ({calc_degree, calc_x, calc_y} !== 23'd0) begin
      n_err++; $display("FAIL reset_calc got %0d/%0d/%0d want 0/0/0", calc_degree, calc_x, calc_y);
    end
    n_vec++; if (rom_en_o !== 1'b0 || rom_addr_o !== 17'd0) begin
      n_err++; $display("FAIL reset_rom got en=%b addr=%0d want en=0 addr=0", rom_en_o, rom_addr_o);
    end
    rst = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_req0();
    set_req(0, 0, 0, 0);
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_vec++; if (rom_en_o !== 1'b1 || rom_addr_o !== 17'd0) begin
      n_err++; $display("FAIL single_rom got en=%b addr=%0d want en=1 addr=0", rom_en_o, rom_addr_o);
    end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early got %b want 00", rsp_valid); end
    tick();
    #1;
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data !== rom_word(17'd0)) begin
      n_err++; $display("FAIL single_rsp got v=%b d=%h want v=01 d=%h", rsp_valid, rsp_data, rom_word(17'd0));
    end
    tick();
  endtask

  task automatic test_req1();
    set_req(1, 200, 10, 2);
    req_valid = 2'b10;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL req1_ready got %b want 10", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_vec++; if (rom_en_o !== 1'b1 || rom_addr_o !== 17'd46210) begin
      n_err++; $display("FAIL req1_rom got en=%b addr=%0d want en=1 addr=46210", rom_en_o, rom_addr_o);
    end
    n_vec++; if (calc_degree !== 9'd200 || calc_x !== 7'd10 || calc_y !== 7'd2) begin
      n_err++; $display("FAIL req1_calc got %0d/%0d/%0d want 200/10/2", calc_degree, calc_x, calc_y);
    end
    tick();
    tick();
    #1;
    n_vec++; if (rsp_valid !== 2'b10 || rsp_data !== rom_word(17'd46210)) begin
      n_err++; $display("FAIL req1_rsp got v=%b d=%h want v=10 d=%h", rsp_valid, rsp_data,
                        rom_word(17'd46210));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] want;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    set_req(0, $urandom_range(0, 359), $urandom_range(0, 74), $urandom_range(0, 74));
    set_req(1, $urandom_range(0, 359), $urandom_range(0, 74), $urandom_range(0, 74));
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 6) ? 2'b11 : 2'b00;
      #1;
      want = (k < 6) ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_vec++; if (req_ready !== want) begin
        n_err++; $display("FAIL b2b_grant[%0d] got %b want %b", k, req_ready, want);
      end
      want = (k >= 3 && k < 9) ? (((k - 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_vec++; if (rsp_valid !== want || (want != 0 && rsp_data !== exp_rsp_data)) begin
        n_err++; $display("FAIL b2b_rsp[%0d] got v=%b d=%h want v=%b d=%h", k, rsp_valid, rsp_data,
                          want, exp_rsp_data);
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) set_req(i, $urandom_range(0, 359), $urandom_range(0, 74), $urandom_range(0, 74));
      end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_req(0, 45, 75, 3);
      else set_req(0, 360, 4, 4);
      req_valid = 2'b01;
      #1;
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL oor_ready[%0d] got %b want 01", t, req_ready); end
      tick();
      req_valid = '0;
      #1;
      n_vec++; if (rom_en_o !== 1'b0) begin n_err++; $display("FAIL oor_rom_en[%0d] got %b want 0", t, rom_en_o); end
      tick();
      tick();
      #1;
      n_vec++; if (rsp_valid !== 2'b01 || rsp_data !== 12'h000) begin
        n_err++; $display("FAIL oor_rsp[%0d] got v=%b d=%h want v=01 d=000", t, rsp_valid, rsp_data);
      end
      // A legal read afterwards so the next transparent check starts from a non-zero pixel.
      set_req(0, 90, 20, 20);
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 300, 33, 44);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    n_vec++; if (rom_en_o !== 1'b1) begin n_err++; $display("FAIL midrst_rom_en got %b want 1", rom_en_o); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if ({calc_degree, calc_x, calc_y} !== 23'd0 || rom_en_o !== 1'b0 || rsp_data !== 12'h000) begin
      n_err++; $display("FAIL midrst_outputs got calc=%0d/%0d/%0d en=%b d=%h want zeros", calc_degree,
                        calc_x, calc_y, rom_en_o, rsp_data);
    end
    for (int k = 2; k <= 5; k++) begin
      n_vec++; if (rsp_valid !== 2'b00) begin
        n_err++; $display("FAIL midrst_rsp[T+%0d] got %b want 00", k, rsp_valid);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_frame_start();
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL fs_first got %b want 01", req_ready); end
    tick();
    req_valid = 2'b11;
    frame_start = 1'b1;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL fs_same got %b want 10", req_ready); end
    tick();
    frame_start = 1'b0;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL fs_after got %b want 01", req_ready); end
`ifdef SPRITE_ARB_STATS_EN
    n_vec++; if (stat_grants !== '0) begin n_err++; $display("FAIL fs_stats got %h want 0", stat_grants); end
`endif
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] hold;
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_req(i, $urandom_range(0, 380), $urandom_range(0, 80), $urandom_range(0, 80));
        end
      end
      frame_start = ($urandom_range(0, 15) == 0);
      #1;
      n_vec++; if (req_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", c, req_ready, exp_ready);
      end
      n_vec++; if (rsp_valid !== exp_rsp_valid || rsp_data !== exp_rsp_data) begin
        n_err++; $display("FAIL rnd_rsp[%0d] got v=%b d=%h want v=%b d=%h", c, rsp_valid, rsp_data,
                          exp_rsp_valid, exp_rsp_data);
      end
      n_vec++; if (rom_en_o !== exp_en || (exp_en && rom_addr_o !== exp_addr)) begin
        n_err++; $display("FAIL rnd_rom[%0d] got en=%b addr=%0d want en=%b addr=%0d", c, rom_en_o,
                          rom_addr_o, exp_en, exp_addr);
      end
      n_vec++; if (calc_degree !== exp_cd || calc_x !== exp_cx || calc_y !== exp_cy) begin
        n_err++; $display("FAIL rnd_calc[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", c, calc_degree,
                          calc_x, calc_y, exp_cd, exp_cx, exp_cy);
      end
      hold = req_valid & ~exp_ready;
      tick();
    end
    req_valid = '0;
    frame_start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_req1();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    test_frame_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
